// File: rtl/cc_logic_pkg.sv
// Shared definitions for the bitwise logic unit family: op-select width and op codes.
package cc_logic_pkg;

    localparam int NUMBER_OPWIDTH = 3;

    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_AND   = 3'b000;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_OR    = 3'b001;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_XOR   = 3'b010;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_NAND  = 3'b011;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_NOR   = 3'b100;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_XNOR  = 3'b101;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_NOTA  = 3'b110;
    localparam logic [NUMBER_OPWIDTH-1:0] CC_OP_PASSA = 3'b111;

endpackage

// File: rtl/cc_logic_op.sv
// Purely combinational DW-wide bitwise op mux. No carries, so each result bit
// depends only on the matching A and B bits; NOT A and PASS A ignore operand B.
module cc_logic_op
    import cc_logic_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic [NUMBER_DATAWIDTH-1:0] i_a,
    input  logic [NUMBER_DATAWIDTH-1:0] i_b,
    input  logic [NUMBER_OPWIDTH-1:0]   i_op,
    output logic [NUMBER_DATAWIDTH-1:0] o_result
);

    // Select the requested bitwise function of A and B
    always_comb begin
        o_result = '0;
        case (i_op)
            CC_OP_AND:   o_result = i_a & i_b;
            CC_OP_OR:    o_result = i_a | i_b;
            CC_OP_XOR:   o_result = i_a ^ i_b;
            CC_OP_NAND:  o_result = ~(i_a & i_b);
            CC_OP_NOR:   o_result = ~(i_a | i_b);
            CC_OP_XNOR:  o_result = ~(i_a ^ i_b);
            CC_OP_NOTA:  o_result = ~i_a;
            CC_OP_PASSA: o_result = i_a;
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/cc_logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides, one register
// stage and an accumulate mode that feeds the last loaded result back as A.
module cc_logic_unit_pipe
    import cc_logic_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                        CC_LOGICUNIT_CLOCK_50,
    input  logic                        CC_LOGICUNIT_RESET_InLow,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICUNIT_dataA_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_LOGICUNIT_dataB_InBUS,
    input  logic [NUMBER_OPWIDTH-1:0]   CC_LOGICUNIT_op_InBUS,
    input  logic                        CC_LOGICUNIT_accumulate_In,
    input  logic                        CC_LOGICUNIT_valid_In,
    output logic                        CC_LOGICUNIT_ready_Out,
    output logic [NUMBER_DATAWIDTH-1:0] CC_LOGICUNIT_OutBUS,
    output logic                        CC_LOGICUNIT_valid_Out,
    input  logic                        CC_LOGICUNIT_ready_In,
    output logic                        CC_LOGICUNIT_zero_Out,
    output logic                        CC_LOGICUNIT_ones_Out
);

    // The result register doubles as the accumulator: acc is by definition the
    // last value loaded into OutBUS, and it only changes on an accepted beat,
    // so it survives a downstream transfer untouched.
    logic [NUMBER_DATAWIDTH-1:0] r_result;
    logic                        r_valid;
    logic                        r_zero;
    logic                        r_ones;

    logic                        w_ready;
    logic                        w_accept;
    logic [NUMBER_DATAWIDTH-1:0] w_operand_a;
    logic [NUMBER_DATAWIDTH-1:0] w_op_result;

    assign w_ready     = !r_valid || CC_LOGICUNIT_ready_In;
    assign w_accept    = CC_LOGICUNIT_valid_In && w_ready;
    assign w_operand_a = CC_LOGICUNIT_accumulate_In ? r_result : CC_LOGICUNIT_dataA_InBUS;

    cc_logic_op #(
        .NUMBER_DATAWIDTH (NUMBER_DATAWIDTH)
    ) u_op (
        .i_a      (w_operand_a),
        .i_b      (CC_LOGICUNIT_dataB_InBUS),
        .i_op     (CC_LOGICUNIT_op_InBUS),
        .o_result (w_op_result)
    );

    // Output stage: load on accept, clear valid on a bare transfer, hold on stall
    always_ff @(posedge CC_LOGICUNIT_CLOCK_50) begin
        if (!CC_LOGICUNIT_RESET_InLow) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b1;
            r_ones   <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_op_result;
            r_valid  <= 1'b1;
            r_zero   <= (w_op_result == '0);
            r_ones   <= (&w_op_result);
        end else if (CC_LOGICUNIT_ready_In) begin
            r_valid  <= 1'b0;
        end
    end

    assign CC_LOGICUNIT_ready_Out = w_ready;
    assign CC_LOGICUNIT_OutBUS    = r_result;
    assign CC_LOGICUNIT_valid_Out = r_valid;
    assign CC_LOGICUNIT_zero_Out  = r_zero;
    assign CC_LOGICUNIT_ones_Out  = r_ones;

endmodule

// File: tb/tb_cc_logic_unit_pipe.sv
// Directed self-checking bench for cc_logic_unit_pipe (DW=8).
module tb_cc_logic_unit_pipe;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [2:0]    op;
    logic          accumulate;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] out_bus;
    logic          valid_out;
    logic          ready_in;
    logic          zero_out;
    logic          ones_out;

    int checks;
    int failures;

    cc_logic_unit_pipe #(
        .NUMBER_DATAWIDTH (DW)
    ) dut (
        .CC_LOGICUNIT_CLOCK_50      (clk),
        .CC_LOGICUNIT_RESET_InLow   (rst_n),
        .CC_LOGICUNIT_dataA_InBUS   (data_a),
        .CC_LOGICUNIT_dataB_InBUS   (data_b),
        .CC_LOGICUNIT_op_InBUS      (op),
        .CC_LOGICUNIT_accumulate_In (accumulate),
        .CC_LOGICUNIT_valid_In      (valid_in),
        .CC_LOGICUNIT_ready_Out     (ready_out),
        .CC_LOGICUNIT_OutBUS        (out_bus),
        .CC_LOGICUNIT_valid_Out     (valid_out),
        .CC_LOGICUNIT_ready_In      (ready_in),
        .CC_LOGICUNIT_zero_Out      (zero_out),
        .CC_LOGICUNIT_ones_Out      (ones_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic acc);
        valid_in   = v;
        op         = o;
        data_a     = a;
        data_b     = b;
        accumulate = acc;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ready_in = 1'b1;
        drive(1'b1, 3'b111, 8'hA5, 8'h00, 1'b0);
        tick();
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", valid_out);
        end
        checks++;
        if (out_bus !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got=%h exp=00", out_bus);
        end
        checks++;
        if (zero_out !== 1'b1 || ones_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got zero=%b ones=%b exp zero=1 ones=0", zero_out, ones_out);
        end
        checks++;
        if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", ready_out);
        end
        $display("reset: valid=%b out=%h zero=%b ready=%b", valid_out, out_bus, zero_out, ready_out);
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_all_ops();
        logic [DW-1:0] exp_tab [8];
        exp_tab[0] = 8'h42; exp_tab[1] = 8'hDB; exp_tab[2] = 8'h99; exp_tab[3] = 8'hBD;
        exp_tab[4] = 8'h24; exp_tab[5] = 8'h66; exp_tab[6] = 8'h3C; exp_tab[7] = 8'hC3;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'hC3, 8'h5A, 1'b0);
            tick();
            checks++;
            if (valid_out !== 1'b1 || out_bus !== exp_tab[i] || zero_out !== 1'b0 || ones_out !== 1'b0) begin
                failures++;
                $display("FAIL op%0d got out=%h valid=%b zero=%b ones=%b exp out=%h valid=1 zero=0 ones=0",
                         i, out_bus, valid_out, zero_out, ones_out, exp_tab[i]);
            end
            $display("op %0d: A=C3 B=5A -> out=%h", i, out_bus);
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
        checks++;
        if (valid_out !== 1'b0 || out_bus !== 8'hC3) begin
            failures++;
            $display("FAIL drain got valid=%b out=%h exp valid=0 out=c3", valid_out, out_bus);
        end
    endtask

    task automatic test_flags();
        ready_in = 1'b1;
        drive(1'b1, 3'b000, 8'hF0, 8'h0F, 1'b0);
        tick();
        checks++;
        if (out_bus !== 8'h00 || zero_out !== 1'b1 || ones_out !== 1'b0) begin
            failures++;
            $display("FAIL flag_zero got out=%h zero=%b ones=%b exp out=00 zero=1 ones=0", out_bus, zero_out, ones_out);
        end
        $display("flags AND F0,0F -> out=%h zero=%b ones=%b", out_bus, zero_out, ones_out);
        drive(1'b1, 3'b001, 8'hF0, 8'h0F, 1'b0);
        tick();
        checks++;
        if (out_bus !== 8'hFF || zero_out !== 1'b0 || ones_out !== 1'b1) begin
            failures++;
            $display("FAIL flag_ones got out=%h zero=%b ones=%b exp out=ff zero=0 ones=1", out_bus, zero_out, ones_out);
        end
        $display("flags OR F0,0F -> out=%h zero=%b ones=%b", out_bus, zero_out, ones_out);
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        ready_in = 1'b0;
        drive(1'b1, 3'b000, 8'hFF, 8'h0F, 1'b0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || out_bus !== 8'h0F) begin
            failures++;
            $display("FAIL bp_first got valid=%b out=%h exp valid=1 out=0f", valid_out, out_bus);
        end
        drive(1'b1, 3'b001, 8'hA0, 8'h05, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ready_out !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready%0d got=%b exp=0", c, ready_out);
            end
            tick();
            checks++;
            if (valid_out !== 1'b1 || out_bus !== 8'h0F || zero_out !== 1'b0 || ones_out !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b out=%h exp valid=1 out=0f", c, valid_out, out_bus);
            end
            $display("stall %0d: out=%h valid=%b ready=%b", c, out_bus, valid_out, ready_out);
        end
        ready_in = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=1", ready_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || out_bus !== 8'hA5) begin
            failures++;
            $display("FAIL bp_second got valid=%b out=%h exp valid=1 out=a5", valid_out, out_bus);
        end
        $display("release: out=%h valid=%b", out_bus, valid_out);
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
        checks++;
        if (valid_out !== 1'b0 || out_bus !== 8'hA5) begin
            failures++;
            $display("FAIL bp_drain got valid=%b out=%h exp valid=0 out=a5", valid_out, out_bus);
        end
    endtask

    task automatic test_accumulate();
        logic [2:0]    ops [5];
        logic [DW-1:0] bs  [5];
        logic [DW-1:0] exp_tab [5];
        ops[0] = 3'b111; bs[0] = 8'h00; exp_tab[0] = 8'hFF;
        ops[1] = 3'b010; bs[1] = 8'h0F; exp_tab[1] = 8'hF0;
        ops[2] = 3'b000; bs[2] = 8'h3C; exp_tab[2] = 8'h30;
        ops[3] = 3'b001; bs[3] = 8'h80; exp_tab[3] = 8'hB0;
        ops[4] = 3'b010; bs[4] = 8'hFF; exp_tab[4] = 8'h4F;
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 8'hFF, bs[i], (i != 0));
            tick();
            checks++;
            if (valid_out !== 1'b1 || out_bus !== exp_tab[i]) begin
                failures++;
                $display("FAIL acc%0d got valid=%b out=%h exp valid=1 out=%h", i, valid_out, out_bus, exp_tab[i]);
            end
            $display("acc beat %0d: out=%h", i, out_bus);
        end
        // Result already consumed downstream; accumulator must still hold B0
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, ops[4], 8'h00, bs[4], 1'b1);
        tick();
        checks++;
        if (valid_out !== 1'b1 || out_bus !== exp_tab[4]) begin
            failures++;
            $display("FAIL acc_after_drain got valid=%b out=%h exp valid=1 out=%h", valid_out, out_bus, exp_tab[4]);
        end
        $display("acc after drain: out=%h", out_bus);
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_stall();
        ready_in = 1'b0;
        drive(1'b1, 3'b111, 8'h55, 8'h00, 1'b0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || out_bus !== 8'h55) begin
            failures++;
            $display("FAIL rst_stall_load got valid=%b out=%h exp valid=1 out=55", valid_out, out_bus);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (valid_out !== 1'b0 || out_bus !== 8'h00 || zero_out !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall_clear got valid=%b out=%h zero=%b exp valid=0 out=00 zero=1",
                     valid_out, out_bus, zero_out);
        end
        rst_n    = 1'b1;
        ready_in = 1'b1;
        drive(1'b1, 3'b001, 8'hEE, 8'h01, 1'b1);
        tick();
        checks++;
        if (valid_out !== 1'b1 || out_bus !== 8'h01) begin
            failures++;
            $display("FAIL rst_stall_acc got valid=%b out=%h exp valid=1 out=01", valid_out, out_bus);
        end
        $display("after mid-stall reset: acc OR 01 -> out=%h", out_bus);
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_all_ops();
        test_flags();
        test_backpressure();
        test_accumulate();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
